fairy_sram_arbiter: RTL and testbench
=====================================

# fairy_sram_arbiter

Shares one single-port synchronous SRAM between the fetch stage and the memory stage of the fairy CPU. Every cycle it picks one requester, drives the SRAM port, and returns the read data one cycle later to the owner of the access. It stalls fetch whenever fetch loses arbitration. A fairness counter keeps back-to-back data traffic from starving instruction fetch, and a flush input drops in-flight fetch responses on exception or eret.

## Interface
Parameters:
- FAIR_LIMIT, 4: maximum consecutive data grants while fetch is waiting; range 1..7.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  reset, asynchronous, active-low
- inst_req_i  in  1  fetch requests a read this cycle
- inst_addr_i  in  32  fetch byte address
- inst_gnt_o  out  1  fetch access issued to SRAM this cycle
- inst_rvalid_o  out  1  inst_rdata_o valid (response to the previous-cycle grant)
- inst_rdata_o  out  32  instruction word; 0 when inst_rvalid_o=0
- fetch_stall_o  out  1  inst_req_i & ~inst_gnt_o
- flush_i  in  1  exception or eret: cancel fetch grant and fetch response this cycle
- data_req_i  in  1  memory stage requests an access
- data_wen_i  in  4  byte write enables; 0 means read
- data_addr_i  in  32  data byte address
- data_wdata_i  in  32  store data
- data_gnt_o  out  1  data access issued this cycle
- data_rvalid_o  out  1  load data valid (reads only)
- data_rdata_o  out  32  load word; 0 when data_rvalid_o=0
- ram_en_o  out  1  SRAM enable
- ram_wen_o  out  4  SRAM byte write enables
- ram_addr_o  out  32  SRAM address
- ram_wdata_o  out  32  SRAM write data
- ram_rdata_i  in  32  SRAM read data, valid one cycle after the enable

## Operation
- Grant logic is combinational from the current inputs and from run_cnt:
  - data_win = data_req_i & (~inst_req_i | flush_i | run_cnt < FAIR_LIMIT)
  - data_gnt_o = data_win
  - inst_gnt_o = inst_req_i & ~flush_i & ~data_win
- While reset_n=0, both grants are forced to 0.
- SRAM mux:
  - On a data grant: ram_addr/wen/wdata come from the data_* inputs.
  - On an inst grant: ram_addr_o = inst_addr_i and ram_wen_o = 0.
  - With no grant: ram_en_o = 0, ram_wen_o = 0, and address and wdata are 0.
  - ram_en_o is the OR of the two grants.
- run_cnt (3 bits) tracks consecutive data grants while fetch waits:
  - Increments, saturating at FAIR_LIMIT, on a data grant with inst_req_i=1.
  - Clears to 0 on an inst grant, or when inst_req_i=0.
  - Otherwise holds.
- Response FSM, state register resp, with three states:
  - IDLE: no read in flight.
  - INST_RD: an inst read was issued last cycle.
  - DATA_RD: a data read was issued last cycle.
  - Next state after each edge: INST_RD if inst granted; DATA_RD if data granted with data_wen_i=0; otherwise IDLE. A data write goes to IDLE.
- Responses:
  - In INST_RD: inst_rvalid_o = ~flush_i, and inst_rdata_o = ram_rdata_i when rvalid is 1, else 0.
  - In DATA_RD: data_rvalid_o = 1 and data_rdata_o = ram_rdata_i. flush_i does not affect data responses.
- Writes complete at grant and produce no rvalid.

## Timing
- Reset (asynchronous assert, synchronous-release use): resp=IDLE, run_cnt=0. All outputs are 0 while reset_n=0.
- Read latency is 1 cycle: grant in cycle N gives rvalid in cycle N+1. A new grant is allowed in cycle N+1, so the arbiter sustains 1 access per cycle.
- A requester holds its request and operands until it sees its grant. The arbiter does not latch requests.
- Simultaneous requests: data wins unless run_cnt has reached FAIR_LIMIT. In that case fetch wins exactly one cycle and run_cnt clears.
- flush_i together with inst_req_i:
  - No inst grant that cycle.
  - Any INST_RD response in the same cycle is suppressed.
  - A pending data request is granted regardless of run_cnt.
- reset_n asserted mid-access: the in-flight response is discarded and resp returns to IDLE immediately.

## Test plan
- Fetch alone: inst_req_i=1 with addresses 0xbfc00000, +4, +8. Required: inst_gnt_o=1 every cycle; ram_addr_o follows the address; inst_rvalid_o=1 one cycle later with the matching ram_rdata_i; fetch_stall_o=0.
- Load collides with fetch: data_req_i=1, wen=0, addr 0x80001000 for 1 cycle. Required:
  - That cycle: data_gnt_o=1, inst_gnt_o=0, fetch_stall_o=1.
  - Next cycle: data_rvalid_o=1 with the SRAM word, and fetch is granted.
- Starvation guard, FAIR_LIMIT=4: data_req_i and inst_req_i held high for 12 cycles. Required grant pattern: D,D,D,D,I,D,D,D,D,I,D,D. run_cnt clears after each I.
- Store: data_wen_i=4'b0011, addr 0x80000004, wdata 0x1234abcd. Required: ram_wen_o=0011 and ram_wdata_o=0x1234abcd in the grant cycle; data_rvalid_o=0 in the next cycle.
- Flush: an inst grant in cycle N, then flush_i=1 in cycle N+1 with inst_req_i=1. Required:
  - Cycle N+1: inst_rvalid_o=0, inst_rdata_o=0, inst_gnt_o=0.
  - Cycle N+2, flush_i=0: grant resumes.
- Reset mid-read: reset_n pulled low in the cycle after a data-read grant. Required: data_rvalid_o drops to 0 immediately. After release, resp=IDLE and run_cnt=0.

Source files
------------

// File: rtl/fairy_sram_arbiter.sv
// fairy_sram_arbiter: shares one single-port synchronous SRAM between fetch and the memory stage.
// Ports: clk, reset_n (async, active-low);
//   fetch side  inst_req_i/inst_addr_i -> inst_gnt_o, inst_rvalid_o, inst_rdata_o, fetch_stall_o; flush_i cancels fetch;
//   data side   data_req_i/data_wen_i/data_addr_i/data_wdata_i -> data_gnt_o, data_rvalid_o, data_rdata_o;
//   SRAM side   ram_en_o/ram_wen_o/ram_addr_o/ram_wdata_o, ram_rdata_i (one-cycle read latency).
module fairy_sram_arbiter #(
    parameter int FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inst_req_i,
    input  logic [31:0] inst_addr_i,
    output logic        inst_gnt_o,
    output logic        inst_rvalid_o,
    output logic [31:0] inst_rdata_o,
    output logic        fetch_stall_o,
    input  logic        flush_i,
    input  logic        data_req_i,
    input  logic [3:0]  data_wen_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        ram_en_o,
    output logic [3:0]  ram_wen_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i
);
    localparam logic [2:0] LIMIT = 3'(FAIR_LIMIT);
    typedef enum logic [1:0] {IDLE, INST_RD, DATA_RD} resp_t;
    resp_t      resp, resp_nxt;
    logic [2:0] run_cnt;
    logic       data_win;
    // Data wins unless fetch has waited through LIMIT data grants; a flush
    // removes fetch from contention so data goes regardless of the count.
    always_comb begin
        data_win      = reset_n & data_req_i & (~inst_req_i | flush_i | (run_cnt < LIMIT));
        data_gnt_o    = data_win;
        inst_gnt_o    = reset_n & inst_req_i & ~flush_i & ~data_win;
        fetch_stall_o = reset_n & inst_req_i & ~inst_gnt_o;
        ram_en_o      = data_win | inst_gnt_o;
        ram_wen_o     = data_win ? data_wen_i : 4'd0;
        ram_addr_o    = data_win ? data_addr_i : inst_gnt_o ? inst_addr_i : 32'd0;
        ram_wdata_o   = data_win ? data_wdata_i : 32'd0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            run_cnt <= 3'd0;
        else if (data_win && inst_req_i)
            run_cnt <= (run_cnt == LIMIT) ? run_cnt : run_cnt + 3'd1;
        else if (inst_gnt_o || !inst_req_i)
            run_cnt <= 3'd0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            resp <= IDLE;
        else
            resp <= resp_nxt;
    end
    // Writes complete at grant, so only reads leave a response in flight.
    always_comb begin
        resp_nxt = inst_gnt_o ? INST_RD : (data_win && data_wen_i == 4'd0) ? DATA_RD : IDLE;
    end
    always_comb begin
        inst_rvalid_o = (resp == INST_RD) & ~flush_i;
        inst_rdata_o  = inst_rvalid_o ? ram_rdata_i : 32'd0;
        data_rvalid_o = (resp == DATA_RD);
        data_rdata_o  = data_rvalid_o ? ram_rdata_i : 32'd0;
    end
endmodule

// File: tb/tb_fairy_sram_arbiter.sv
// tb_fairy_sram_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_fairy_sram_arbiter;
    localparam int FL = 4;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        inst_req_i = 1'b0, flush_i = 1'b0, data_req_i = 1'b0;
    logic [31:0] inst_addr_i = '0, data_addr_i = '0, data_wdata_i = '0, ram_rdata_i = '0;
    logic [3:0]  data_wen_i = '0;
    logic        inst_gnt_o, inst_rvalid_o, fetch_stall_o, data_gnt_o, data_rvalid_o, ram_en_o;
    logic [31:0] inst_rdata_o, data_rdata_o, ram_addr_o, ram_wdata_o;
    logic [3:0]  ram_wen_o;
    int          checks = 0;
    int          fails = 0;
    int          streak = 0;
    int          last = 0;

    fairy_sram_arbiter #(.FAIR_LIMIT(FL)) dut (
        .clk(clk), .reset_n(reset_n),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
        .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o), .fetch_stall_o(fetch_stall_o),
        .flush_i(flush_i), .data_req_i(data_req_i), .data_wen_i(data_wen_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .ram_en_o(ram_en_o),
        .ram_wen_o(ram_wen_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o),
        .ram_rdata_i(ram_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: streak = data grants fetch has sat through since it last got
    // served or stopped asking; last = who owns the read answered this cycle
    // (0 nobody, 1 fetch, 2 data).
    function automatic logic e_dgnt();
        return reset_n && data_req_i && (!inst_req_i || flush_i || streak < FL);
    endfunction
    function automatic logic e_ignt();
        return reset_n && inst_req_i && !flush_i && !e_dgnt();
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak <= 0;
            last   <= 0;
        end else begin
            last   <= e_ignt() ? 1 : (e_dgnt() && data_wen_i == 4'd0) ? 2 : 0;
            streak <= (!inst_req_i || e_ignt()) ? 0 : e_dgnt() ? ((streak < FL) ? streak + 1 : FL) : streak;
        end
    end

    always @(negedge clk) begin
        logic dg, ig, irv, drv;
        #4;
        dg  = e_dgnt();
        ig  = e_ignt();
        irv = reset_n && last == 1 && !flush_i;
        drv = reset_n && last == 2;
        chk("inst_gnt", 32'(inst_gnt_o), 32'(ig));
        chk("data_gnt", 32'(data_gnt_o), 32'(dg));
        chk("fetch_stall", 32'(fetch_stall_o), 32'(reset_n && inst_req_i && !ig));
        chk("inst_rvalid", 32'(inst_rvalid_o), 32'(irv));
        chk("inst_rdata", inst_rdata_o, irv ? ram_rdata_i : 32'd0);
        chk("data_rvalid", 32'(data_rvalid_o), 32'(drv));
        chk("data_rdata", data_rdata_o, drv ? ram_rdata_i : 32'd0);
        chk("ram_en", 32'(ram_en_o), 32'(dg || ig));
        chk("ram_wen", 32'(ram_wen_o), dg ? 32'(data_wen_i) : 32'd0);
        chk("ram_addr", ram_addr_o, dg ? data_addr_i : ig ? inst_addr_i : 32'd0);
        chk("ram_wdata", ram_wdata_o, dg ? data_wdata_i : 32'd0);
    end

    task automatic set(input logic ir, input logic [31:0] ia, input logic fl, input logic dr,
                       input logic [3:0] w, input logic [31:0] da, input logic [31:0] wd);
        inst_req_i   = ir;
        inst_addr_i  = ia;
        flush_i      = fl;
        data_req_i   = dr;
        data_wen_i   = w;
        data_addr_i  = da;
        data_wdata_i = wd;
        ram_rdata_i  = $urandom;
    endtask

    initial begin
        logic [31:0] prev;
        string       pat;
        pat = "DDDDIDDDDIDD";
        prev = '0;
        repeat (2) @(negedge clk);
        set(1, 32'hbfc00000, 0, 1, 4'hf, 32'h80000000, 32'hffffffff);
        #4;
        chk("rst_ram_en", 32'(ram_en_o), 32'd0);
        chk("rst_ram_addr", ram_addr_o, 32'd0);
        chk("rst_stall", 32'(fetch_stall_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set(1, 32'hbfc00000 + 32'(4 * k), 0, 0, 0, 0, 0);
            #4;
            chk("fetch_gnt", 32'(inst_gnt_o), 32'd1);
            chk("fetch_addr", ram_addr_o, 32'hbfc00000 + 32'(4 * k));
            chk("fetch_stall0", 32'(fetch_stall_o), 32'd0);
            if (k > 0) chk("fetch_rvalid", 32'(inst_rvalid_o), 32'd1);
            prev = ram_rdata_i;
            if (k > 0) chk("fetch_rdata", inst_rdata_o, prev);
            @(negedge clk);
        end
        set(1, 32'hbfc0000c, 0, 1, 0, 32'h80001000, 0);
        #4;
        chk("ld_dgnt", 32'(data_gnt_o), 32'd1);
        chk("ld_ignt", 32'(inst_gnt_o), 32'd0);
        chk("ld_stall", 32'(fetch_stall_o), 32'd1);
        chk("ld_addr", ram_addr_o, 32'h80001000);
        @(negedge clk);
        set(1, 32'hbfc0000c, 0, 0, 0, 0, 0);
        #4;
        chk("ld_rvalid", 32'(data_rvalid_o), 32'd1);
        chk("ld_rdata", data_rdata_o, ram_rdata_i);
        chk("ld_fetch_resume", 32'(inst_gnt_o), 32'd1);
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            set(1, 32'hbfc00010, 0, 1, 0, 32'h80001000 + 32'(4 * i), 0);
            #4;
            chk("fair_pattern", 32'({data_gnt_o, inst_gnt_o}), (pat[i] == "D") ? 32'd2 : 32'd1);
            @(negedge clk);
        end
        set(0, 0, 0, 1, 4'b0011, 32'h80000004, 32'h1234abcd);
        #4;
        chk("st_wen", 32'(ram_wen_o), 32'h3);
        chk("st_wdata", ram_wdata_o, 32'h1234abcd);
        chk("st_addr", ram_addr_o, 32'h80000004);
        @(negedge clk);
        set(0, 0, 0, 0, 0, 0, 0);
        #4;
        chk("st_no_rvalid", 32'(data_rvalid_o), 32'd0);
        @(negedge clk);
        set(1, 32'hbfc00100, 0, 0, 0, 0, 0);
        #4;
        chk("fl_gnt_n", 32'(inst_gnt_o), 32'd1);
        @(negedge clk);
        set(1, 32'hbfc00104, 1, 0, 0, 0, 0);
        #4;
        chk("fl_rvalid", 32'(inst_rvalid_o), 32'd0);
        chk("fl_rdata", inst_rdata_o, 32'd0);
        chk("fl_gnt", 32'(inst_gnt_o), 32'd0);
        @(negedge clk);
        set(1, 32'hbfc00104, 0, 0, 0, 0, 0);
        #4;
        chk("fl_resume", 32'(inst_gnt_o), 32'd1);
        @(negedge clk);
        set(0, 0, 0, 1, 0, 32'h80002000, 0);
        #4;
        chk("rr_dgnt", 32'(data_gnt_o), 32'd1);
        @(negedge clk);
        set(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("rr_rvalid_pre", 32'(data_rvalid_o), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rr_rvalid_drop", 32'(data_rvalid_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #4;
        chk("rr_idle_d", 32'(data_rvalid_o), 32'd0);
        chk("rr_idle_i", 32'(inst_rvalid_o), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            set(1, 32'hbfc00200, 0, 1, 0, 32'h80003000, 0);
            #4;
            chk("rr_cnt_zero", 32'({data_gnt_o, inst_gnt_o}), (i < 4) ? 32'd2 : 32'd1);
            @(negedge clk);
        end
        for (int i = 0; i < 3000; i++) begin
            set(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 9) == 0),
                1'($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom),
                $urandom, $urandom);
            reset_n = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
